// File: rtl/cntr_updn.sv
// Up/down modulo counter with clear, clamped parallel load, end-of-range decodes and a wrap pulse.
// Latency: q and wrap update one clock after the qualifying edge; at_max/at_min decode q combinationally.
// No backpressure: one action per edge, priority rst > clr > ld > count. Define CNTR_SAT_EN for saturating mode.
module cntr_updn #(
    parameter int W    = 3,
    parameter int MOD  = 2**W,
    parameter int INIT = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         ld,
    input  logic [W-1:0] d,
    input  logic         c_up,
    input  logic         c_dn,
    output logic [W-1:0] q,
    output logic         at_max,
    output logic         at_min,
    output logic         wrap
);

    localparam logic [W-1:0] MAX_V   = W'(MOD - 1);
    localparam logic [W-1:0] INIT_V  = W'(INIT);
    localparam logic [W-1:0] ONE_V   = W'(1);
    // One extra bit so MOD == 2**W is representable for the load range test.
    localparam logic [W:0]   MOD_EXT = (W+1)'(MOD);

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;
    logic         d_in_range;

    assign d_in_range = ({1'b0, d} < MOD_EXT);

`ifdef CNTR_SAT_EN
    // Next-state: clear, clamped load, or saturating count.
    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = INIT_V;
        end else if (ld) begin
            q_d = d_in_range ? d : MAX_V;
        end else if (c_up && !c_dn) begin
            q_d = (q_q == MAX_V) ? MAX_V : (q_q + ONE_V);
        end else if (c_dn && !c_up) begin
            q_d = (q_q == '0) ? '0 : (q_q - ONE_V);
        end
    end

    // Counter register; no wrap state exists in saturating mode.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= INIT_V;
        end else begin
            q_q <= q_d;
        end
    end

    assign wrap = 1'b0;
`else
    logic wrap_q;
    logic wrap_d;

    // Next-state: clear, clamped load, or modulo count with wrap detection.
    always_comb begin
        q_d    = q_q;
        wrap_d = 1'b0;
        if (clr) begin
            q_d = INIT_V;
        end else if (ld) begin
            q_d = d_in_range ? d : MAX_V;
        end else if (c_up && !c_dn) begin
            if (q_q == MAX_V) begin
                q_d    = '0;
                wrap_d = 1'b1;
            end else begin
                q_d = q_q + ONE_V;
            end
        end else if (c_dn && !c_up) begin
            if (q_q == '0) begin
                q_d    = MAX_V;
                wrap_d = 1'b1;
            end else begin
                q_d = q_q - ONE_V;
            end
        end
    end

    // Counter and wrap-pulse registers; wrap lines up with the first wrapped q.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_q    <= INIT_V;
            wrap_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            wrap_q <= wrap_d;
        end
    end

    assign wrap = wrap_q;
`endif

    assign q      = q_q;
    assign at_max = (q_q == MAX_V);
    assign at_min = (q_q == '0);

endmodule

// File: tb/tb_cntr_updn.sv
module tb_cntr_updn;

`ifdef CNTR_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       clr = 1'b0;
    logic       ld = 1'b0;
    logic [2:0] d = 3'd0;
    logic       c_up = 1'b0;
    logic       c_dn = 1'b0;

    logic [2:0] q, q_i2, q_m8;
    logic       at_max, at_min, wrap;
    logic       at_max_i2, at_min_i2, wrap_i2;
    logic       at_max_m8, at_min_m8, wrap_m8;
    logic [0:0] q_m2, d_m2;
    logic       at_max_m2, at_min_m2, wrap_m2;

    int tests = 0;
    int fails = 0;

    assign d_m2 = d[0:0];

    always #5 clk = ~clk;

    cntr_updn #(.W(3), .MOD(6), .INIT(0)) u_dut (
        .clk(clk), .rst(rst), .clr(clr), .ld(ld), .d(d), .c_up(c_up), .c_dn(c_dn),
        .q(q), .at_max(at_max), .at_min(at_min), .wrap(wrap));

    cntr_updn #(.W(3), .MOD(6), .INIT(2)) u_init2 (
        .clk(clk), .rst(rst), .clr(clr), .ld(ld), .d(d), .c_up(c_up), .c_dn(c_dn),
        .q(q_i2), .at_max(at_max_i2), .at_min(at_min_i2), .wrap(wrap_i2));

    cntr_updn #(.W(3), .MOD(8), .INIT(0)) u_mod8 (
        .clk(clk), .rst(rst), .clr(clr), .ld(ld), .d(d), .c_up(c_up), .c_dn(c_dn),
        .q(q_m8), .at_max(at_max_m8), .at_min(at_min_m8), .wrap(wrap_m8));

    cntr_updn #(.W(1), .MOD(2), .INIT(0)) u_mod2 (
        .clk(clk), .rst(rst), .clr(clr), .ld(ld), .d(d_m2), .c_up(c_up), .c_dn(c_dn),
        .q(q_m2), .at_max(at_max_m2), .at_min(at_min_m2), .wrap(wrap_m2));

    // Advance one edge, then sample 1 time unit later (away from the edge).
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic c, input logic l, input logic [2:0] dv,
                         input logic up, input logic dn);
        rst = r; clr = c; ld = l; d = dv; c_up = up; c_dn = dn;
    endtask

    task automatic test_reset();
        logic [2:0] exp_q;
        drive(1, 0, 0, 3'd0, 1, 0);
        step();
        step();
        tests++;
        if (q !== 3'd0 || wrap !== 1'b0 || at_min !== 1'b1 || at_max !== 1'b0) begin
            fails++;
            $display("FAIL reset: q=%0d wrap=%b at_min=%b at_max=%b, want q=0 wrap=0 at_min=1 at_max=0",
                     q, wrap, at_min, at_max);
        end
        tests++;
        if (q_i2 !== 3'd2) begin
            fails++;
            $display("FAIL reset_init2: q=%0d want 2", q_i2);
        end
        rst = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            step();
            exp_q = 3'(i);
            tests++;
            if (q !== exp_q || wrap !== 1'b0 || at_max !== (i == 5) || at_min !== 1'b0) begin
                fails++;
                $display("FAIL count_up[%0d]: q=%0d wrap=%b at_max=%b at_min=%b, want q=%0d wrap=0 at_max=%b at_min=0",
                         i, q, wrap, at_max, at_min, exp_q, (i == 5));
            end
        end
    endtask

    task automatic test_wrap_up();
        // q is 5 here with c_up still held.
        step();
        tests++;
        if (q !== (SAT ? 3'd5 : 3'd0) || wrap !== !SAT) begin
            fails++;
            $display("FAIL wrap_up: q=%0d wrap=%b, want q=%0d wrap=%b", q, wrap, (SAT ? 5 : 0), !SAT);
        end
        step();
        tests++;
        if (q !== (SAT ? 3'd5 : 3'd1) || wrap !== 1'b0) begin
            fails++;
            $display("FAIL wrap_up_after: q=%0d wrap=%b, want q=%0d wrap=0", q, wrap, (SAT ? 5 : 1));
        end
    endtask

    task automatic test_wrap_down();
        logic [2:0] exp_q;
        drive(0, 0, 1, 3'd0, 0, 0);
        step();
        drive(0, 0, 0, 3'd0, 0, 1);
        step();
        exp_q = SAT ? 3'd0 : 3'd5;
        tests++;
        if (q !== exp_q || wrap !== !SAT || at_max !== !SAT || at_min !== SAT) begin
            fails++;
            $display("FAIL wrap_down: q=%0d wrap=%b, want q=%0d wrap=%b", q, wrap, exp_q, !SAT);
        end
        drive(0, 0, 0, 3'd0, 1, 1);
        step();
        tests++;
        if (q !== exp_q || wrap !== 1'b0) begin
            fails++;
            $display("FAIL both_hold: q=%0d wrap=%b, want q=%0d wrap=0", q, wrap, exp_q);
        end
        drive(0, 0, 1, 3'd3, 0, 0);
        step();
        drive(0, 0, 0, 3'd0, 0, 1);
        step();
        tests++;
        if (q !== 3'd2 || wrap !== 1'b0) begin
            fails++;
            $display("FAIL dec_mid: q=%0d wrap=%b, want q=2 wrap=0", q, wrap);
        end
    endtask

    task automatic test_load_clear();
        drive(0, 0, 1, 3'd3, 1, 0);
        step();
        tests++;
        if (q !== 3'd3 || wrap !== 1'b0) begin
            fails++;
            $display("FAIL load_wins: q=%0d wrap=%b, want q=3 wrap=0", q, wrap);
        end
        drive(0, 0, 1, 3'd7, 0, 0);
        step();
        tests++;
        if (q !== 3'd5 || at_max !== 1'b1) begin
            fails++;
            $display("FAIL load_clamp: q=%0d at_max=%b, want q=5 at_max=1", q, at_max);
        end
        tests++;
        if (q_m8 !== 3'd7 || at_max_m8 !== 1'b1) begin
            fails++;
            $display("FAIL load_mod8: q=%0d at_max=%b, want q=7 at_max=1", q_m8, at_max_m8);
        end
        // Load at the top while counting up must not wrap.
        drive(0, 0, 1, 3'd1, 1, 0);
        step();
        tests++;
        if (q !== 3'd1 || wrap !== 1'b0) begin
            fails++;
            $display("FAIL load_over_wrap: q=%0d wrap=%b, want q=1 wrap=0", q, wrap);
        end
        drive(0, 1, 1, 3'd3, 1, 0);
        step();
        tests++;
        if (q !== 3'd0 || at_min !== 1'b1) begin
            fails++;
            $display("FAIL clr_wins: q=%0d at_min=%b, want q=0 at_min=1", q, at_min);
        end
        tests++;
        if (q_i2 !== 3'd2 || at_min_i2 !== 1'b0) begin
            fails++;
            $display("FAIL clr_init2: q=%0d at_min=%b, want q=2 at_min=0", q_i2, at_min_i2);
        end
    endtask

    task automatic test_rst_mid_count();
        drive(0, 0, 1, 3'd3, 0, 0);
        step();
        drive(0, 0, 0, 3'd0, 1, 0);
        step();
        tests++;
        if (q !== 3'd4) begin
            fails++;
            $display("FAIL pre_rst_count: q=%0d, want 4", q);
        end
        rst = 1'b1;
        step();
        tests++;
        if (q !== 3'd0 || wrap !== 1'b0 || at_min !== 1'b1) begin
            fails++;
            $display("FAIL rst_mid_count: q=%0d wrap=%b, want q=0 wrap=0", q, wrap);
        end
        // Full-range modulus: wrap comes from natural overflow.
        drive(0, 0, 1, 3'd7, 0, 0);
        step();
        drive(0, 0, 0, 3'd0, 1, 0);
        step();
        tests++;
        if (q_m8 !== (SAT ? 3'd7 : 3'd0) || wrap_m8 !== !SAT) begin
            fails++;
            $display("FAIL mod8_wrap: q=%0d wrap=%b, want q=%0d wrap=%b", q_m8, wrap_m8, (SAT ? 7 : 0), !SAT);
        end
        c_up = 1'b0;
        clr = 1'b1;
        step();
        tests++;
        if (wrap_m8 !== 1'b0 || q_m8 !== 3'd0) begin
            fails++;
            $display("FAIL clr_kills_wrap: q=%0d wrap=%b, want q=0 wrap=0", q_m8, wrap_m8);
        end
        clr = 1'b0;
    endtask

    task automatic test_back_to_back();
        drive(1, 0, 0, 3'd0, 0, 0);
        step();
        drive(0, 0, 0, 3'd0, 0, 1);
        step();
        tests++;
        if (q_m2 !== (SAT ? 1'b0 : 1'b1) || wrap_m2 !== !SAT) begin
            fails++;
            $display("FAIL b2b_first: q=%0d wrap=%b, want q=%0d wrap=%b", q_m2, wrap_m2, (SAT ? 0 : 1), !SAT);
        end
        drive(0, 0, 0, 3'd0, 1, 0);
        step();
        tests++;
        if (q_m2 !== (SAT ? 1'b1 : 1'b0) || wrap_m2 !== !SAT) begin
            fails++;
            $display("FAIL b2b_second: q=%0d wrap=%b, want q=%0d wrap=%b", q_m2, wrap_m2, (SAT ? 1 : 0), !SAT);
        end
        drive(0, 0, 1, 3'd1, 1, 0);
        step();
        tests++;
        if (q_m2 !== 1'b1 || wrap_m2 !== 1'b0 || at_max_m2 !== 1'b1 || at_min_m2 !== 1'b0) begin
            fails++;
            $display("FAIL b2b_load: q=%0d wrap=%b, want q=1 wrap=0", q_m2, wrap_m2);
        end
    endtask

    task automatic test_saturate();
        logic [2:0] exp_q;
        drive(0, 0, 1, 3'd5, 0, 0);
        step();
        drive(0, 0, 0, 3'd0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            exp_q = SAT ? 3'd5 : 3'(i);
            tests++;
            if (q !== exp_q || wrap !== (!SAT && i == 0)) begin
                fails++;
                $display("FAIL sat_up[%0d]: q=%0d wrap=%b, want q=%0d wrap=%b", i, q, wrap, exp_q, (!SAT && i == 0));
            end
        end
        c_up = 1'b0;
    endtask

    initial begin
        test_reset();
        test_wrap_up();
        test_wrap_down();
        test_load_clear();
        test_rst_mid_count();
        test_back_to_back();
        test_saturate();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
